// File: rtl/cml_frame_fmt.sv
// CameraLink video timing formatter.
// Turns an AXI4-Stream pixel stream into FVAL/LVAL/DVAL plus tap data for the CameraLink
// transmitter. It inserts frame lead/trail and horizontal/vertical blanking. It also polices
// line length and start-of-frame, and resynchronises on the next SOF after an error.
module cml_frame_fmt #(
  parameter int unsigned COL         = 1280,
  parameter int unsigned ROW         = 1024,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned TAPS        = 3,
  parameter int unsigned FV_LEAD     = 4,
  parameter int unsigned FV_TRAIL    = 4,
  parameter int unsigned H_BLANK     = 16,
  parameter int unsigned V_BLANK     = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [PIXEL_WIDTH*TAPS-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tuser,
  input  logic                        i_err_clr,
  output logic                        o_fval,
  output logic                        o_lval,
  output logic                        o_dval,
  output logic [PIXEL_WIDTH*TAPS-1:0] o_data,
  output logic                        o_len_err,
  output logic                        o_sync_err,
  output logic [15:0]                 o_frame_cnt
);

  localparam int unsigned DataW = PIXEL_WIDTH * TAPS;
  localparam int unsigned Beats = COL / TAPS;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned LineW = (ROW > 1) ? $clog2(ROW) : 1;

  // One shared phase counter covers lead, blanking and trail.
  // Trail needs FV_TRAIL+1 counts because its first cycle is spent dropping LVAL.
  localparam int unsigned MaxA   = (FV_LEAD > H_BLANK) ? FV_LEAD : H_BLANK;
  localparam int unsigned MaxB   = (V_BLANK > FV_TRAIL + 1) ? V_BLANK : FV_TRAIL + 1;
  localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StLine,
    StHblank,
    StDiscard,
    StTrail,
    StVblank
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [LineW-1:0]   line_q, line_d;
  logic               fval_q, fval_d;
  logic               lval_q, lval_d;
  logic               dval_q, dval_d;
  logic [DataW-1:0]   data_q, data_d;
  logic               len_err_q, len_err_d;
  logic               sync_err_q, sync_err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               tready;
  logic               len_set;
  logic               sync_set;
  logic               first_beat;
  logic               last_beat;
  logic               last_line;
  logic               bad_sof;

  // Decode the position within the frame.
  always_comb begin
    first_beat = (beat_q == '0) && (line_q == '0);
    last_beat  = (beat_q == BeatW'(Beats - 1));
    last_line  = (line_q == LineW'(ROW - 1));
    // Only beat 0 of line 0 may carry SOF. Any other SOF is held back and aborts the frame.
    bad_sof    = s_axis_tvalid && s_axis_tuser && !first_beat;
  end

  // Next-state, handshake and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    line_d      = line_q;
    fval_d      = fval_q;
    lval_d      = lval_q;
    dval_d      = 1'b0;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    len_set     = 1'b0;
    sync_set    = 1'b0;
    tready      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // SOF is left on the bus so that LINE consumes it as beat 0.
        tready = !s_axis_tuser;
        if (s_axis_tvalid) begin
          if (s_axis_tuser) begin
            state_d = StLead;
            fval_d  = 1'b1;
            cnt_d   = '0;
            beat_d  = '0;
            line_d  = '0;
          end else begin
            sync_set = 1'b1;
          end
        end
      end

      StLead: begin
        if (cnt_q == CntW'(FV_LEAD - 1)) begin
          state_d = StLine;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StLine: begin
        tready = !(s_axis_tuser && !first_beat);
        if (bad_sof) begin
          sync_set = 1'b1;
          fval_d   = 1'b0;
          lval_d   = 1'b0;
          cnt_d    = '0;
          state_d  = StVblank;
        end else if (s_axis_tvalid) begin
          dval_d = 1'b1;
          lval_d = 1'b1;
          data_d = s_axis_tdata;
          if (s_axis_tlast) begin
            // A short line still counts as a line.
            len_set = !last_beat;
            beat_d  = '0;
            line_d  = line_q + LineW'(1);
            cnt_d   = '0;
            state_d = last_line ? StTrail : StHblank;
          end else if (last_beat) begin
            // The line is full but has no tlast, so the rest of the line is dropped.
            len_set = 1'b1;
            beat_d  = '0;
            state_d = StDiscard;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end

      StDiscard: begin
        tready = !s_axis_tuser;
        lval_d = 1'b0;
        if (s_axis_tvalid && s_axis_tuser) begin
          sync_set = 1'b1;
          fval_d   = 1'b0;
          cnt_d    = '0;
          state_d  = StVblank;
        end else if (s_axis_tvalid && s_axis_tlast) begin
          line_d  = line_q + LineW'(1);
          cnt_d   = '0;
          state_d = last_line ? StTrail : StHblank;
        end
      end

      StHblank: begin
        lval_d = 1'b0;
        if (cnt_q == CntW'(H_BLANK - 1)) begin
          state_d = StLine;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StTrail: begin
        // Count 0 drops LVAL. FVAL then stays up for FV_TRAIL more cycles.
        lval_d = 1'b0;
        if (cnt_q == CntW'(FV_TRAIL)) begin
          fval_d      = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          cnt_d       = '0;
          state_d     = StVblank;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StVblank: begin
        if (cnt_q == CntW'(V_BLANK - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        fval_d  = 1'b0;
        lval_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // Sticky flags: a new error wins over a simultaneous clear.
    len_err_d  = len_set  || (len_err_q  && !i_err_clr);
    sync_err_d = sync_set || (sync_err_q && !i_err_clr);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      dval_q      <= 1'b0;
      data_q      <= '0;
      len_err_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      dval_q      <= dval_d;
      data_q      <= data_d;
      len_err_q   <= len_err_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_axis_tready = tready;
  assign o_fval        = fval_q;
  assign o_lval        = lval_q;
  assign o_dval        = dval_q;
  assign o_data        = data_q;
  assign o_len_err     = len_err_q;
  assign o_sync_err    = sync_err_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cml_frame_fmt.sv
// Directed bench for cml_frame_fmt: a cycle vector table for frame start, then driven frames
// observed by a timing monitor.
`timescale 1ns / 1ps
module tb_cml_frame_fmt;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          i_err_clr = 1'b0;
  logic          o_fval, o_lval, o_dval, o_len_err, o_sync_err;
  logic [DW-1:0] o_data;
  logic [15:0]   o_frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cml_frame_fmt #(
    .COL(12), .ROW(3), .PIXEL_WIDTH(8), .TAPS(3),
    .FV_LEAD(2), .FV_TRAIL(2), .H_BLANK(2), .V_BLANK(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .i_err_clr(i_err_clr),
    .o_fval(o_fval), .o_lval(o_lval), .o_dval(o_dval), .o_data(o_data),
    .o_len_err(o_len_err), .o_sync_err(o_sync_err), .o_frame_cnt(o_frame_cnt)
  );

  // Timing monitor: records dval per line, LVAL gaps, FVAL lead/trail and vertical gaps.
  int   line_q[$], gap_q[$], lead_q[$], trail_q[$], vlow_q[$], fcnt_q[$], data_q[$];
  int   cur_d = 0, low_cnt = 0, lead_cnt = 0, vlow_cnt = 0, fval_rises = 0, inv_viol = 0;
  logic in_lead = 1'b0, prev_fval = 1'b0, prev_lval = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_fval = 1'b0;
      prev_lval = 1'b0;
      in_lead   = 1'b0;
    end else begin
      if (!o_fval && (o_lval || o_dval)) inv_viol++;
      if (o_fval && !prev_fval) begin
        in_lead  = 1'b1;
        lead_cnt = 0;
        fval_rises++;
        vlow_q.push_back(vlow_cnt);
      end
      if (o_lval && !prev_lval) begin
        if (in_lead) lead_q.push_back(lead_cnt);
        else gap_q.push_back(low_cnt);
        in_lead = 1'b0;
        cur_d   = 0;
      end
      if (!o_lval && prev_lval) begin
        line_q.push_back(cur_d);
        low_cnt = 0;
      end
      if (o_dval) begin
        cur_d++;
        data_q.push_back(int'(o_data));
      end
      if (o_fval && !o_lval) begin
        if (in_lead) lead_cnt++;
        else low_cnt++;
      end
      if (!o_fval && prev_fval) begin
        trail_q.push_back(low_cnt);
        fcnt_q.push_back(int'(o_frame_cnt));
        vlow_cnt = 0;
      end
      if (!o_fval) vlow_cnt++;
      prev_fval = o_fval;
      prev_lval = o_lval;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    line_q.delete(); gap_q.delete(); lead_q.delete(); trail_q.delete();
    vlow_q.delete(); fcnt_q.delete(); data_q.delete();
  endtask

  // Starts and ends at posedge+1. A beat is accepted at the posedge after a negedge with tready=1.
  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    bit acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: data 0x%0h never accepted within 200 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends nb beats of base+b. tlast goes on beat tl, and SOF on beat 0 when sof is set.
  task automatic send_line(input int base, input int nb, input int tl, input bit sof,
                           input bit gap);
    for (int b = 0; b < nb; b++) begin
      send_beat(DW'(base + b), sof && (b == 0), b == tl);
      if (gap) idle(1);
    end
  endtask

  task automatic err_clr();
    i_err_clr = 1'b1;
    @(posedge clk);
    #1;
    i_err_clr = 1'b0;
  endtask

  task automatic sample_at_negedge();
    @(negedge clk);
  endtask

  typedef struct {
    logic          tvalid, tuser, tlast;
    logic [DW-1:0] tdata;
    logic          e_ready, e_fval, e_lval, e_dval;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Frame start, cycle by cycle. Columns: inputs, then expected tready/fval/lval/dval/data.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 24'h00, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00}; // idle
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 24'h11, 1'b0, 1'b0, 1'b0, 1'b0, 24'h00}; // SOF held
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 24'h11, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00}; // lead 0
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 24'h11, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00}; // lead 1
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 24'h11, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00}; // SOF taken
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 24'h22, 1'b1, 1'b1, 1'b1, 1'b1, 24'h11};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 24'h00, 1'b1, 1'b1, 1'b1, 1'b1, 24'h22}; // stall
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 24'h33, 1'b1, 1'b1, 1'b1, 1'b0, 24'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 24'h44, 1'b1, 1'b1, 1'b1, 1'b1, 24'h33}; // tlast
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 24'h00, 1'b0, 1'b1, 1'b1, 1'b1, 24'h44}; // hblank 0
    vecs[10] = '{1'b0, 1'b0, 1'b0, 24'h00, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00}; // hblank 1
    vecs[11] = '{1'b0, 1'b0, 1'b0, 24'h00, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00}; // line 1

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_fval", o_fval, 0);
    check("rst_lval", o_lval, 0);
    check("rst_dval", o_dval, 0);
    check("rst_frame_cnt", o_frame_cnt, 0);
    check("rst_errs", {o_len_err, o_sync_err}, 0);
    reset_n = 1'b1;
    idle(2);

    // Frame 0: vector table, then the remaining lines are driven.
    clear_mon();
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = vecs[i].tvalid;
      s_axis_tuser  = vecs[i].tuser;
      s_axis_tlast  = vecs[i].tlast;
      s_axis_tdata  = vecs[i].tdata;
      @(negedge clk);
      check($sformatf("vec%0d_tready", i), s_axis_tready, vecs[i].e_ready);
      check($sformatf("vec%0d_fval", i), o_fval, vecs[i].e_fval);
      check($sformatf("vec%0d_lval", i), o_lval, vecs[i].e_lval);
      check($sformatf("vec%0d_dval", i), o_dval, vecs[i].e_dval);
      if (vecs[i].e_dval) check($sformatf("vec%0d_data", i), o_data, vecs[i].e_data);
      @(posedge clk);
      #1;
    end
    send_line(24'h55, 4, 3, 0, 0);
    send_line(24'h99, 4, 3, 0, 0);
    idle(12);
    check("f0_lines", line_q.size(), 3);
    check("f0_frame_cnt", o_frame_cnt, 1);

    // 1: clean frame with tvalid held high.
    clear_mon();
    for (int l = 0; l < 3; l++) send_line(l * 4 + 1, 4, 3, l == 0, 0);
    idle(12);
    check("t1_lead", lead_q[0], 3); // FV_LEAD cycles in LEAD plus one cycle of beat latency
    check("t1_nlines", line_q.size(), 3);
    for (int l = 0; l < 3; l++) check($sformatf("t1_line%0d_dval", l), line_q[l], 4);
    check("t1_gap0", gap_q[0], 2);
    check("t1_gap1", gap_q[1], 2);
    check("t1_trail", trail_q[0], 2);
    check("t1_frame_cnt", o_frame_cnt, 2);
    check("t1_len_err", o_len_err, 0);
    check("t1_sync_err", o_sync_err, 0);
    for (int i = 0; i < 12; i++) check($sformatf("t1_data%0d", i), data_q[i], i + 1);

    // 2: tvalid toggles 1010, so LVAL must still cover each line without gaps.
    clear_mon();
    for (int l = 0; l < 3; l++) send_line(l * 4 + 1, 4, 3, l == 0, 1);
    idle(12);
    check("t2_nlines", line_q.size(), 3);
    for (int l = 0; l < 3; l++) check($sformatf("t2_line%0d_dval", l), line_q[l], 4);
    check("t2_ndata", data_q.size(), 12);
    for (int i = 0; i < 12; i++) check($sformatf("t2_data%0d", i), data_q[i], i + 1);
    check("t2_frame_cnt", o_frame_cnt, 3);

    // 3: early tlast on beat 1 of line 1.
    clear_mon();
    send_line(1, 4, 3, 1, 0);
    send_line(5, 2, 1, 0, 0);
    send_line(7, 4, 3, 0, 0);
    idle(12);
    check("t3_nlines", line_q.size(), 3);
    check("t3_line1_dval", line_q[1], 2);
    check("t3_line2_dval", line_q[2], 4);
    check("t3_trail", trail_q[0], 2);
    check("t3_len_err", o_len_err, 1);
    check("t3_frame_cnt", o_frame_cnt, 4);
    err_clr();
    sample_at_negedge();
    check("t3_len_err_clr", o_len_err, 0);
    @(posedge clk);
    #1;

    // 4: 6-beat line with tlast on beat 5; beats 4-5 are dropped.
    clear_mon();
    send_line(1, 6, 5, 1, 0);
    send_line(7, 4, 3, 0, 0);
    send_line(11, 4, 3, 0, 0);
    idle(12);
    check("t4_line0_dval", line_q[0], 4);
    check("t4_ndata", data_q.size(), 12);
    check("t4_data3", data_q[3], 4);
    check("t4_data4", data_q[4], 7);
    check("t4_len_err", o_len_err, 1);
    check("t4_frame_cnt", o_frame_cnt, 5);
    err_clr();

    // 5: unexpected SOF on line 1 beat 2 aborts the frame; the held beat starts the next one.
    clear_mon();
    send_line(1, 4, 3, 1, 0);
    send_line(5, 2, 9, 0, 0);
    send_beat(24'h77, 1'b1, 1'b0);
    send_line(24'h78, 3, 2, 0, 0);
    send_line(24'h80, 4, 3, 0, 0);
    send_line(24'h90, 4, 3, 0, 0);
    idle(12);
    check("t5_sync_err", o_sync_err, 1);
    check("t5_len_err", o_len_err, 0);
    check("t5_abort_line_dval", line_q[1], 2);
    check("t5_abort_frame_cnt", fcnt_q[0], 5);
    check("t5_vblank_gap", vlow_q[1], 4); // V_BLANK cycles plus the IDLE cycle that sees SOF
    check("t5_held_beat", data_q[6], 24'h77);
    check("t5_nlines", line_q.size(), 5);
    check("t5_next_frame_cnt", o_frame_cnt, 6);

    // 6: beats without SOF in IDLE are dropped. A set and a clear in the same cycle keep the flag.
    err_clr();
    sample_at_negedge();
    check("t6_sync_err_clr", o_sync_err, 0);
    @(posedge clk);
    #1;
    clear_mon();
    begin
      int rises0;
      rises0 = fval_rises;
      i_err_clr = 1'b1;
      send_beat(24'h05, 1'b0, 1'b0);
      i_err_clr = 1'b0;
      sample_at_negedge();
      check("t6_set_beats_clr", o_sync_err, 1);
      @(posedge clk);
      #1;
      send_beat(24'h06, 1'b0, 1'b0);
      send_beat(24'h07, 1'b0, 1'b1);
      idle(6);
      check("t6_fval_low", o_fval, 0);
      check("t6_no_fval_rise", fval_rises, rises0);
      check("t6_no_dval", data_q.size(), 0);
    end

    // Reset mid-line clears all registered outputs immediately.
    send_beat(24'h100, 1'b1, 1'b0);
    send_beat(24'h101, 1'b0, 1'b0);
    send_beat(24'h102, 1'b0, 1'b0);
    check("t6_pre_rst_lval", o_lval, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_fval", o_fval, 0);
    check("t6_rst_lval", o_lval, 0);
    check("t6_rst_dval", o_dval, 0);
    check("t6_rst_data", o_data, 0);
    check("t6_rst_errs", {o_len_err, o_sync_err}, 0);
    check("t6_rst_frame_cnt", o_frame_cnt, 0);
    check("inv_lval_dval_under_fval", inv_viol, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
